mskaes_host_driver: RTL
=======================

Name: mskaes_host_driver

Overview:
- Initiator-side companion to the masked round-based AES-128 encryption core.
- Accepts unmasked plaintext and key over a valid/ready handshake and splits both into 2-share bit-interleaved sharings using an internal LFSR PRNG.
- Drives the core's valid_in/ready handshake and supplies fresh randomness buses every cycle.
- Captures the one-cycle ciphertext shares when the core raises cipher_valid, unmasks them, and presents the result over an output valid/ready handshake with a timeout watchdog.

Parameters:
RZ_W, 160, width of core_rnd_z (20*rnd_busz of the core)
RB_W, 20, width of core_rnd_b (20*rnd_busb of the core)
TIMEOUT, 255, maximum cycles in RUN before abort
CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
seed_valid  in  1  load PRNG seed (honoured in IDLE only)
seed  in  128  PRNG seed; all-zero seed is replaced by 128'h1
in_valid  in  1  plaintext/key offered
in_ready  out  1  driver accepts input
plaintext  in  128  unmasked plaintext, bit 0 = LSB
key  in  128  unmasked key
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts ciphertext
ciphertext  out  128  unmasked ciphertext
timeout_err  out  1  sticky abort flag
busy  out  1  state != IDLE
core_valid_in  out  1  to core valid_in
core_ready  in  1  from core ready
core_cipher_valid  in  1  from core cipher_valid
core_sh_plaintext  out  256  share0 at bit 2i, share1 at bit 2i+1
core_sh_key  out  256  same interleave as plaintext
core_sh_ciphertext  in  256  same interleave as plaintext
core_rnd_z  out  RZ_W  fresh randomness
core_rnd_b  out  RB_W  fresh randomness

Behaviour:
- Reset (nrst=0 at posedge clk; applies mid-operation too):
  - state = IDLE, seeded = 0, PRNG state = 128'h1.
  - All outputs 0: in_ready, out_valid, core_valid_in, timeout_err, busy, ciphertext, sh buses, rnd buses.
- PRNG:
  - 128-bit Fibonacci LFSR with polynomial x^128+x^7+x^2+x+1, unrolled to OUT_W = 512+RZ_W+RB_W steps per enabled cycle.
  - Advances every cycle while seeded = 1.
  - Output slices, in order: mask_pt[127:0], mask_key[255:128], rnd_z, rnd_b.
- IDLE:
  - in_ready = seeded.
  - seed_valid loads the seed (zero substituted) and sets seeded = 1. in_ready stays 0 during that cycle.
  - in_valid & in_ready: register shares from the current PRNG output (mask m):
    - sh_pt[2i] = pt[i]^m_pt[i], sh_pt[2i+1] = m_pt[i].
    - sh_key[2i] = key[i]^m_key[i], sh_key[2i+1] = m_key[i].
  - Then clear timeout_err and go to LOAD.
- LOAD:
  - core_valid_in = 1; shares held stable.
  - On core_ready = 1, the core fetches in the same cycle; clear the counter and go to RUN next cycle.
  - seed_valid is ignored.
- RUN:
  - core_valid_in = 0; sh buses driven to 0 to avoid lingering shares.
  - Counter increments each cycle.
  - core_cipher_valid = 1: ciphertext[i] <= sh_ct[2i]^sh_ct[2i+1], captured that exact cycle (the core shows shares for one cycle only). Go to OUT.
  - Counter == TIMEOUT without cipher_valid: timeout_err <= 1, go to IDLE.
  - If cipher_valid and timeout coincide, cipher_valid wins.
- OUT:
  - out_valid = 1; ciphertext held until out_ready.
  - On out_ready, go to IDLE. in_ready rises the following cycle, so there is no same-cycle re-accept.
- rnd buses:
  - Driven from the PRNG in LOAD and RUN.
  - 0 in IDLE and OUT.
- Latencies:
  - Input accept → core_valid_in: 1 cycle.
  - cipher_valid → out_valid: 1 cycle.
- Unmasked ciphertext is the only unmasked secret-dependent register.

Decomposition:
- Shared package mskaes_host_pkg:
  - state enum {IDLE, LOAD, RUN, OUT}.
  - LFSR_W = 128, LFSR_TAPS, SEED_DEFAULT = 128'h1.
  - interleave/deinterleave functions.
- Sub-module mskaes_lfsr_prng(clk, nrst, en, load, seed, out[OUT_W-1:0]), parameterised OUT_W.

Test Plan:
- FIPS-197 vector, real core, seed 0x0123...cdef, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid one cycle after cipher_valid.
- Sharing check, same input → XOR of share pairs equals pt/key bitwise; odd shares equal the PRNG slice; odd shares non-constant across two runs with identical input.
- Unseeded, in_valid = 1 for 20 cycles → in_ready = 0, no core_valid_in; seed = 0 → PRNG loads 128'h1, in_ready = 1 next cycle.
- Stub core holds core_ready = 0 for 5 cycles in LOAD → core_valid_in stays 1 with stable shares, RUN entered the cycle after core_ready.
- Stub core never asserts cipher_valid, TIMEOUT = 16 → after 16 RUN cycles timeout_err = 1, IDLE; next accepted input clears timeout_err.
- out_ready held 0 for 10 cycles, then nrst = 0 mid-RUN on a second op → ciphertext stable while waiting; after reset all outputs 0 and seeded = 0.

Source files
------------

// File: rtl/mskaes_host_pkg.sv
// Shared types, LFSR constants and share (de)interleaving helpers for the
// masked AES host driver.
package mskaes_host_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

    localparam int LFSR_W = 128;
    // x^128 + x^7 + x^2 + x + 1: feedback from bits 127, 6, 1, 0
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 128'h8000_0000_0000_0000_0000_0000_0000_0043;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 128'h1;

    function automatic logic [2*LFSR_W-1:0] interleave(input logic [LFSR_W-1:0] s0,
                                                       input logic [LFSR_W-1:0] s1);
        logic [2*LFSR_W-1:0] r;
        r = '0;
        for (int i = 0; i < LFSR_W; i++) begin
            r[2*i]   = s0[i];
            r[2*i+1] = s1[i];
        end
        return r;
    endfunction

    function automatic logic [LFSR_W-1:0] deinterleave_xor(input logic [2*LFSR_W-1:0] sh);
        logic [LFSR_W-1:0] r;
        r = '0;
        for (int i = 0; i < LFSR_W; i++) begin
            r[i] = sh[2*i] ^ sh[2*i+1];
        end
        return r;
    endfunction

endpackage

// File: rtl/mskaes_lfsr_prng.sv
// 128-bit Fibonacci LFSR unrolled OUT_W steps per enabled cycle; out is the
// sequence of feedback bits produced from the current state, bit 0 first.
module mskaes_lfsr_prng
    import mskaes_host_pkg::*;
#(
    parameter int OUT_W = 692
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [OUT_W-1:0]  out
);

    logic [LFSR_W-1:0] state;
    logic [LFSR_W-1:0] state_nxt;

    always_comb begin
        logic [LFSR_W-1:0] s;
        s   = state;
        out = '0;
        for (int k = 0; k < OUT_W; k++) begin
            out[k] = ^(s & LFSR_TAPS);
            s      = {s[LFSR_W-2:0], out[k]};
        end
        state_nxt = s;
    end

    // An all-zero seed would lock the LFSR, so it is replaced by the default.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= SEED_DEFAULT;
        end else if (load) begin
            state <= (seed == '0) ? SEED_DEFAULT : seed;
        end else if (en) begin
            state <= state_nxt;
        end
    end

endmodule

// File: rtl/mskaes_host_driver.sv
// Host-side driver for the masked AES-128 core: masks plaintext/key into
// interleaved 2-share buses, feeds fresh randomness, and unmasks the result.
module mskaes_host_driver
    import mskaes_host_pkg::*;
#(
    parameter int RZ_W    = 160,
    parameter int RB_W    = 20,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            seed_valid,
    input  logic [127:0]    seed,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    plaintext,
    input  logic [127:0]    key,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    ciphertext,
    output logic            timeout_err,
    output logic            busy,
    output logic            core_valid_in,
    input  logic            core_ready,
    input  logic            core_cipher_valid,
    output logic [255:0]    core_sh_plaintext,
    output logic [255:0]    core_sh_key,
    input  logic [255:0]    core_sh_ciphertext,
    output logic [RZ_W-1:0] core_rnd_z,
    output logic [RB_W-1:0] core_rnd_b
);

    localparam int OUT_W = 512 + RZ_W + RB_W;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             seeded;
    logic [CNT_W-1:0] cnt;
    logic [255:0]     sh_pt;
    logic [255:0]     sh_key;
    logic [127:0]     ct_q;
    logic             to_q;
    logic [OUT_W-1:0] prng_out;
    logic [127:0]     mask_pt;
    logic [127:0]     mask_key;
    logic             accept;
    logic             rnd_on;
    logic             unused_prng;

    mskaes_lfsr_prng #(.OUT_W(OUT_W)) u_prng (
        .clk  (clk),
        .nrst (nrst),
        .en   (seeded),
        .load (seed_valid && (state == IDLE)),
        .seed (seed),
        .out  (prng_out)
    );

    assign mask_pt     = prng_out[127:0];
    assign mask_key    = prng_out[255:128];
    assign unused_prng = ^prng_out[OUT_W-1:256+RZ_W+RB_W];

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid never waits on ready, and data holds while valid.
    assign in_ready = (state == IDLE) && seeded && !seed_valid;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state  <= IDLE;
            seeded <= 1'b0;
            cnt    <= '0;
            sh_pt  <= '0;
            sh_key <= '0;
            ct_q   <= '0;
            to_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_valid) begin
                        seeded <= 1'b1;
                    end else if (accept) begin
                        sh_pt  <= interleave(plaintext ^ mask_pt, mask_pt);
                        sh_key <= interleave(key ^ mask_key, mask_key);
                        to_q   <= 1'b0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // Core fetches this cycle; drop shares so nothing lingers.
                    if (core_ready) begin
                        cnt    <= '0;
                        sh_pt  <= '0;
                        sh_key <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (core_cipher_valid) begin
                        ct_q  <= deinterleave_xor(core_sh_ciphertext);
                        state <= OUT;
                    end else if (cnt == TO_LAST) begin
                        to_q  <= 1'b1;
                        state <= IDLE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rnd_on            = (state == LOAD) || (state == RUN);
    assign busy              = (state != IDLE);
    assign core_valid_in     = (state == LOAD);
    assign out_valid         = (state == OUT);
    assign ciphertext        = ct_q;
    assign timeout_err       = to_q;
    assign core_sh_plaintext = sh_pt;
    assign core_sh_key       = sh_key;
    assign core_rnd_z        = rnd_on ? prng_out[256 +: RZ_W] : '0;
    assign core_rnd_b        = rnd_on ? prng_out[256+RZ_W +: RB_W] : '0;

endmodule
